tetris_map_update: RTL and testbench

TETRIS_MAP_UPDATE -- requirements
Module: tetris_map_update

---
 rtl/tetris_pkg.sv | 11 +
 rtl/tetris_map_update.sv | 134 +++++++++++++
 tb/tb_tetris_map_update.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: playfield dimensions, coordinate widths and lock FSM encoding,
// shared with the display side.
package tetris_pkg;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int XW = 4;
  localparam int YW = 5;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/tetris_map_update.sv
// tetris_map_update: locks a four-cell piece into the playfield, then scans
// bottom-up one row per cycle removing full rows and keeping line statistics.
module tetris_map_update #(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_req,
  input  logic [tetris_pkg::XW-1:0] cell_x0,
  input  logic [tetris_pkg::XW-1:0] cell_x1,
  input  logic [tetris_pkg::XW-1:0] cell_x2,
  input  logic [tetris_pkg::XW-1:0] cell_x3,
  input  logic [tetris_pkg::YW-1:0] cell_y0,
  input  logic [tetris_pkg::YW-1:0] cell_y1,
  input  logic [tetris_pkg::YW-1:0] cell_y2,
  input  logic [tetris_pkg::YW-1:0] cell_y3,
  input  logic clear_req,
  input  logic [tetris_pkg::XW-1:0] q_x,
  input  logic [tetris_pkg::YW-1:0] q_y,
  output logic q_occ,
  output logic [COLS-1:0] Row1,
  output logic [COLS-1:0] Row2,
  output logic [COLS-1:0] Row3,
  output logic [COLS-1:0] Row4,
  output logic [COLS-1:0] Row5,
  output logic [COLS-1:0] Row6,
  output logic [COLS-1:0] Row7,
  output logic [COLS-1:0] Row8,
  output logic [COLS-1:0] Row9,
  output logic [COLS-1:0] Row10,
  output logic [COLS-1:0] Row11,
  output logic [COLS-1:0] Row12,
  output logic [COLS-1:0] Row13,
  output logic [COLS-1:0] Row14,
  output logic [COLS-1:0] Row15,
  output logic [COLS-1:0] Row16,
  output logic [COLS-1:0] Row17,
  output logic [COLS-1:0] Row18,
  output logic [COLS-1:0] Row19,
  output logic [COLS-1:0] Row20,
  output logic ready,
  output logic done,
  output logic [2:0] lines_cleared,
  output logic [15:0] lines_total,
  output logic top_out
);
  import tetris_pkg::*;
  logic [1:0] state;
  logic [YW-1:0] r;
  logic [COLS-1:0] map [1:ROWS];
  logic [COLS-1:0] lockMap [1:ROWS];
  logic [COLS-1:0] shiftMap [1:ROWS];
  logic [XW-1:0] cx [4];
  logic [YW-1:0] cy [4];
  logic hitTop;
  logic rowFull;
  logic [16:0] totalSum;
  assign cx = '{cell_x0, cell_x1, cell_x2, cell_x3};
  assign cy = '{cell_y0, cell_y1, cell_y2, cell_y3};
  assign rowFull = &map[r];
  assign totalSum = {1'b0, lines_total} + {14'd0, lines_cleared};
  assign ready = state == IDLE;
  assign done = state == DONE;
  always_comb begin
    hitTop = 1'b0;
    lockMap = map;
    shiftMap[1] = '0;
    for (int i = 2; i <= ROWS; i++)
      shiftMap[i] = YW'(i) > r ? map[i] : map[i-1];
    for (int c = 0; c < 4; c++)
      if (cx[c] < XW'(COLS) && cy[c] != '0 && cy[c] <= YW'(ROWS)) begin
        lockMap[cy[c]][cx[c]] = 1'b1;
        hitTop = hitTop | (cy[c] == YW'(1));
      end
  end
  // out-of-range queries read as wall/floor
  always_comb begin
    q_occ = 1'b1;
    if (q_x < XW'(COLS) && q_y != '0 && q_y <= YW'(ROWS))
      q_occ = map[q_y][q_x];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      r <= YW'(ROWS);
      map <= '{default: '0};
      lines_cleared <= '0;
      lines_total <= '0;
      top_out <= 1'b0;
    end else if (state == IDLE) begin
      if (clear_req) begin
        map <= '{default: '0};
        top_out <= 1'b0;
      end else if (lock_req) begin
        map <= lockMap;
        top_out <= top_out | hitTop;
        lines_cleared <= '0;
        r <= YW'(ROWS);
        state <= SCAN;
      end
    end else if (state == SCAN) begin
      if (rowFull) begin
        map <= shiftMap;
        lines_cleared <= lines_cleared + 3'd1;
      end else if (r == YW'(1))
        state <= DONE;
      else
        r <= r - YW'(1);
    end else begin
      lines_total <= totalSum[16] ? 16'hFFFF : totalSum[15:0];
      state <= IDLE;
    end
  assign Row1 = map[1];
  assign Row2 = map[2];
  assign Row3 = map[3];
  assign Row4 = map[4];
  assign Row5 = map[5];
  assign Row6 = map[6];
  assign Row7 = map[7];
  assign Row8 = map[8];
  assign Row9 = map[9];
  assign Row10 = map[10];
  assign Row11 = map[11];
  assign Row12 = map[12];
  assign Row13 = map[13];
  assign Row14 = map[14];
  assign Row15 = map[15];
  assign Row16 = map[16];
  assign Row17 = map[17];
  assign Row18 = map[18];
  assign Row19 = map[19];
  assign Row20 = map[20];
endmodule

// File: tb/tb_tetris_map_update.sv
// tb_tetris_map_update: table-driven and randomized locks checked against a
// row-compaction model of the playfield.
module tb_tetris_map_update;
  logic clk = 1'b0, rst = 1'b0, lock_req = 1'b0, clear_req = 1'b0;
  logic [3:0] cell_x0 = '0, cell_x1 = '0, cell_x2 = '0, cell_x3 = '0, q_x = '0;
  logic [4:0] cell_y0 = '0, cell_y1 = '0, cell_y2 = '0, cell_y3 = '0, q_y = '0;
  logic q_occ, ready, done, top_out;
  logic [2:0] lines_cleared;
  logic [15:0] lines_total;
  logic [9:0] Row1, Row2, Row3, Row4, Row5, Row6, Row7, Row8, Row9, Row10;
  logic [9:0] Row11, Row12, Row13, Row14, Row15, Row16, Row17, Row18, Row19, Row20;
  logic [9:0] dr [1:20];
  logic [9:0] m [1:20];
  int mTotal, mK;
  logic mTop;
  int chks = 0, errs = 0;
  typedef struct {
    logic [15:0] xs;
    logic [19:0] ys;
    int expK;
    int rowIdx;
    logic [9:0] expRow;
  } vec_t;
  vec_t tbl [14];
  always #5 clk = ~clk;
  tetris_map_update dut (
    .clk(clk), .rst(rst), .lock_req(lock_req),
    .cell_x0(cell_x0), .cell_x1(cell_x1), .cell_x2(cell_x2), .cell_x3(cell_x3),
    .cell_y0(cell_y0), .cell_y1(cell_y1), .cell_y2(cell_y2), .cell_y3(cell_y3),
    .clear_req(clear_req), .q_x(q_x), .q_y(q_y), .q_occ(q_occ),
    .Row1(Row1), .Row2(Row2), .Row3(Row3), .Row4(Row4), .Row5(Row5),
    .Row6(Row6), .Row7(Row7), .Row8(Row8), .Row9(Row9), .Row10(Row10),
    .Row11(Row11), .Row12(Row12), .Row13(Row13), .Row14(Row14), .Row15(Row15),
    .Row16(Row16), .Row17(Row17), .Row18(Row18), .Row19(Row19), .Row20(Row20),
    .ready(ready), .done(done), .lines_cleared(lines_cleared),
    .lines_total(lines_total), .top_out(top_out)
  );
  assign dr[1] = Row1;   assign dr[2] = Row2;   assign dr[3] = Row3;   assign dr[4] = Row4;
  assign dr[5] = Row5;   assign dr[6] = Row6;   assign dr[7] = Row7;   assign dr[8] = Row8;
  assign dr[9] = Row9;   assign dr[10] = Row10; assign dr[11] = Row11; assign dr[12] = Row12;
  assign dr[13] = Row13; assign dr[14] = Row14; assign dr[15] = Row15; assign dr[16] = Row16;
  assign dr[17] = Row17; assign dr[18] = Row18; assign dr[19] = Row19; assign dr[20] = Row20;

  task automatic check(input string name, input int act, input int want);
    chks++;
    if (act != want) begin
      errs++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 1; i <= 20; i++) m[i] = '0;
    mTotal = 0;
    mK = 0;
    mTop = 1'b0;
  endtask

  // drop the piece in place, then compact away every full row (gravity only above them)
  task automatic modelLock(input logic [15:0] xs, input logic [19:0] ys, output int k);
    logic [9:0] nr [1:20];
    int d;
    for (int c = 0; c < 4; c++) begin
      int x = int'(xs[4*c +: 4]);
      int y = int'(ys[5*c +: 5]);
      if (x < 10 && y >= 1 && y <= 20) begin
        m[y][x] = 1'b1;
        if (y == 1) mTop = 1'b1;
      end
    end
    for (int i = 1; i <= 20; i++) nr[i] = '0;
    k = 0;
    d = 20;
    for (int s = 20; s >= 1; s--)
      if (m[s] == 10'h3FF) k++;
      else begin
        nr[d] = m[s];
        d--;
      end
    m = nr;
    mK = k;
    mTotal = (mTotal + k > 65535) ? 65535 : mTotal + k;
  endtask

  task automatic checkMap(input string tag);
    for (int i = 1; i <= 20; i++) check($sformatf("%s row%0d", tag, i), int'(dr[i]), int'(m[i]));
    check({tag, " top_out"}, int'(top_out), int'(mTop));
    check({tag, " lines_total"}, int'(lines_total), mTotal);
    check({tag, " lines_cleared"}, int'(lines_cleared), mK);
    check({tag, " ready"}, int'(ready), 1);
    check({tag, " done"}, int'(done), 0);
  endtask

  task automatic setCells(input logic [15:0] xs, input logic [19:0] ys);
    {cell_x3, cell_x2, cell_x1, cell_x0} = xs;
    {cell_y3, cell_y2, cell_y1, cell_y0} = ys;
  endtask

  task automatic doLock(input logic [15:0] xs, input logic [19:0] ys, input bit noise, output int k);
    int n = 0;
    @(negedge clk);
    setCells(xs, ys);
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    setCells(16'hFFFF, '0);
    modelLock(xs, ys, k);
    check("ready low after accept", int'(ready), 0);
    while (!done && n < 100) begin
      if (noise && n == 5) begin
        setCells(16'h5555, {4{5'd10}});
        lock_req = 1'b1;
        clear_req = 1'b1;
      end else begin
        lock_req = 1'b0;
        clear_req = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    lock_req = 1'b0;
    clear_req = 1'b0;
    check("done latency", n, 20 + k);
    check("lines_cleared at done", int'(lines_cleared), k);
    check("ready in DONE", int'(ready), 0);
    @(negedge clk);
    checkMap("after lock");
  endtask

  task automatic clearMap();
    @(negedge clk);
    clear_req = 1'b1;
    lock_req = 1'b1;
    setCells(16'h3210, {4{5'd20}});
    @(negedge clk);
    clear_req = 1'b0;
    lock_req = 1'b0;
    for (int i = 1; i <= 20; i++) m[i] = '0;
    mTop = 1'b0;
    checkMap("clear");
  endtask

  task automatic qCheck(input int x, input int y);
    int want;
    q_x = 4'(x);
    q_y = 5'(y);
    #1;
    if (x > 9 || y == 0 || y > 20) want = 1;
    else want = int'(m[y][x]);
    check($sformatf("q_occ(%0d,%0d)", x, y), int'(q_occ), want);
  endtask

  initial begin
    int k;
    logic [15:0] rx;
    logic [19:0] ry;
    tbl[0]  = '{16'h3210, {4{5'd20}}, 0, 20, 10'h00F};
    tbl[1]  = '{16'h7654, {4{5'd20}}, 0, 20, 10'h0FF};
    tbl[2]  = '{16'h0C98, {5'd0, 5'd5, 5'd20, 5'd20}, 1, 20, 10'h000};
    tbl[3]  = '{16'h4321, {4{5'd17}}, 0, 17, 10'h01E};
    tbl[4]  = '{16'h8765, {4{5'd17}}, 0, 17, 10'h1FE};
    tbl[5]  = '{16'h4321, {4{5'd18}}, 0, 18, 10'h01E};
    tbl[6]  = '{16'h8765, {4{5'd18}}, 0, 18, 10'h1FE};
    tbl[7]  = '{16'h4321, {4{5'd19}}, 0, 19, 10'h01E};
    tbl[8]  = '{16'h8765, {4{5'd19}}, 0, 19, 10'h1FE};
    tbl[9]  = '{16'h4321, {4{5'd20}}, 0, 20, 10'h01E};
    tbl[10] = '{16'h8765, {4{5'd20}}, 0, 20, 10'h1FE};
    tbl[11] = '{16'h9999, {5'd20, 5'd19, 5'd18, 5'd17}, 0, 19, 10'h3FE};
    tbl[12] = '{16'h0000, {5'd20, 5'd19, 5'd18, 5'd17}, 4, 17, 10'h000};
    tbl[13] = '{16'h4F44, {5'd21, 5'd0, 5'd1, 5'd1}, 0, 1, 10'h010};
    modelReset();
    repeat (2) @(negedge clk);
    checkMap("reset");
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      doLock(tbl[i].xs, tbl[i].ys, 1'b0, k);
      check($sformatf("vec%0d lines_cleared", i), int'(lines_cleared), tbl[i].expK);
      check($sformatf("vec%0d row%0d", i, tbl[i].rowIdx), int'(dr[tbl[i].rowIdx]), int'(tbl[i].expRow));
    end
    check("top_out after row1 lock", int'(top_out), 1);
    check("lines_total after table", int'(lines_total), 5);
    clearMap();
    check("top_out after clear", int'(top_out), 0);
    doLock(16'h3210, {4{5'd20}}, 1'b1, k);
    check("ignored lock row10", int'(Row10), 0);
    check("ignored clear row20", int'(Row20), 10'h00F);
    qCheck(10, 5);
    qCheck(4, 21);
    qCheck(0, 20);
    qCheck(5, 20);
    qCheck(3, 0);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) clearMap();
      for (int c = 0; c < 4; c++) begin
        rx[4*c +: 4] = 4'($urandom_range(0, 11));
        ry[5*c +: 5] = 5'($urandom_range(14, 21));
      end
      doLock(rx, ry, t % 5 == 0, k);
      for (int j = 0; j < 3; j++) qCheck(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)));
    end
    clearMap();
    doLock(16'h3210, {4{5'd20}}, 1'b0, k);
    doLock(16'h7654, {4{5'd20}}, 1'b0, k);
    @(negedge clk);
    setCells(16'h0C98, {5'd0, 5'd5, 5'd20, 5'd20});
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset lines_cleared", int'(lines_cleared), 1);
    rst = 1'b0;
    #1;
    for (int i = 1; i <= 20; i++) check($sformatf("midscan reset row%0d", i), int'(dr[i]), 0);
    check("midscan reset ready", int'(ready), 1);
    check("midscan reset done", int'(done), 0);
    check("midscan reset lines_cleared", int'(lines_cleared), 0);
    check("midscan reset lines_total", int'(lines_total), 0);
    check("midscan reset top_out", int'(top_out), 0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    doLock(16'h3210, {4{5'd20}}, 1'b0, k);
    check("post-reset row20", int'(Row20), 10'h00F);
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end
endmodule
